kbd_scan_ctrl: RTL and testbench
================================

// Module: kbd_scan_ctrl
//
// PURPOSE
// Sequences raw PS/2 set-2 scancode bytes into ASCII characters for the CPU. Tracks
// break (F0) and extended (E0) prefixes and Shift state. Drives the combinational
// scancode-to-ASCII mapper and receives its result. Queues each printable character
// in a small show-ahead FIFO read by the CPU's keyboard MMIO register.
//
// PARAMETERS
// FIFO_DEPTH   8          character queue depth; power of 2, >= 2
// TIMEOUT_CYC  1_000_000  idle cycles in a prefix state before forced return to IDLE
//
// PORTS
// clk          in   1  system clock
// reset        in   1  asynchronous, active-high reset
// scan_valid   in   1  1-cycle strobe: scan_code holds a new byte from the PS/2 receiver
// scan_code    in   8  received scancode byte
// map_scan     out  8  byte presented to mapper; = scan_code (combinational)
// map_ascii    in   8  mapper result; 0 = unmapped; letters arrive uppercase 0x41..0x5A
// rd_data      out  8  FIFO head character; valid only while rd_valid=1
// rd_valid     out  1  FIFO not empty
// rd_ack       in   1  pop head; ignored when rd_valid=0
// fifo_full    out  1  FIFO holds FIFO_DEPTH entries
// overflow     out  1  sticky: a character was dropped because the FIFO was full
// ovf_clear    in   1  clears overflow; if a drop occurs in the same cycle, overflow stays 1
//
// BEHAVIOUR
// - Reset (async, any cycle, incl. mid-prefix): state=IDLE, shift=0, FIFO empty,
//   rd_valid=0, rd_data=0, fifo_full=0, overflow=0, timeout counter=0.
// - Bytes are processed only on cycles with scan_valid=1.
// - FSM:
//   IDLE:     F0 -> BREAK; E0 -> EXT; 12/59 -> shift=1, stay.
//             AA, FA, FE, 00, FF -> discard, stay.
//             Any other byte -> push candidate, stay.
//   BREAK:    12/59 -> shift=0; any other byte discarded -> IDLE.
//   EXT:      F0 -> EXT_BRK; any other byte discarded (extended keys unsupported) -> IDLE.
//   EXT_BRK:  any byte discarded -> IDLE.
// - Timeout: counter increments each cycle in BREAK/EXT/EXT_BRK without scan_valid.
//   Reaching TIMEOUT_CYC-1 forces IDLE. Counter is 0 in IDLE and on every scan_valid.
// - Push candidate: if map_ascii==0, nothing is pushed.
//   If map_ascii is in 0x41..0x5A and shift=0, push map_ascii+0x20 (lowercase).
//   Otherwise push map_ascii unchanged; digits ignore shift.
// - Latency: push written on the scan_valid edge; rd_valid/rd_data reflect it the
//   following cycle. rd_data is show-ahead (head visible without a pop).
// - Full: push while full and no pop in that cycle -> char dropped, overflow<=1.
//   Push and pop in the same cycle while full -> both performed, no drop.
//   Push and pop while empty -> push only; no bypass.
// - Pointers carry one extra wrap bit: full = MSBs differ and index bits equal.
//   Pointers wrap modulo 2*FIFO_DEPTH.
//
// STRUCTURE
// - kbd_pkg: kbd_state_e {IDLE, BREAK, EXT, EXT_BRK}.
//   Constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59,
//   SC_BAT=8'hAA, SC_ACK=8'hFA, SC_RESEND=8'hFE, ASCII_CASE_OFS=8'h20.
// - Sub-module kbd_char_fifo (DEPTH, WIDTH=8): show-ahead sync FIFO, push/pop/full/empty.
// - kbd_scan_ctrl holds the FSM, shift flag, timeout counter and overflow flag.
//   The mapper is instantiated beside it by the parent.
//
// TESTING
// 1. Bytes 1C, F0, 1C -> one entry 0x61 ('a'); rd_valid rises 1 cycle after the 1C strobe.
// 2. Bytes 12, 1C, F0, 12, 1C -> entries 0x41, 0x61; shift=0 at end.
// 3. Bytes E0, 75, E0, F0, 75, 16 (unmapped) -> FIFO stays empty; state=IDLE.
// 4. Nine makes of 69 with no rd_ack, DEPTH=8 -> 8 entries of 0x31, fifo_full=1,
//    overflow=1. Strobe ovf_clear -> overflow=0. Full + push + rd_ack same cycle
//    -> no drop, count stays 8.
// 5. F0, then idle TIMEOUT_CYC cycles, then 12 -> shift=1 (byte handled from IDLE).
// 6. Assert reset in EXT with 3 entries queued -> all outputs 0 immediately, FIFO empty.
//    Next 70 -> 0x30 queued.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard scan path.
// Holds the sequencer states, scancode constants and ASCII case helpers.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BREAK   = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_e;

    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_LSHIFT      = 8'h12;
    localparam logic [7:0] SC_RSHIFT      = 8'h59;
    localparam logic [7:0] SC_BAT         = 8'hAA;
    localparam logic [7:0] SC_ACK         = 8'hFA;
    localparam logic [7:0] SC_RESEND      = 8'hFE;
    localparam logic [7:0] SC_ERR_LO      = 8'h00;
    localparam logic [7:0] SC_ERR_HI      = 8'hFF;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;
    localparam logic [7:0] ASCII_UC_FIRST = 8'h41;
    localparam logic [7:0] ASCII_UC_LAST  = 8'h5A;

    function automatic logic is_shift(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

    function automatic logic is_discard(input logic [7:0] code);
        return (code == SC_BAT) || (code == SC_ACK) ||
               (code == SC_RESEND) || (code == SC_ERR_LO) ||
               (code == SC_ERR_HI);
    endfunction

    // The mapper only emits uppercase letters; lowercase is derived here.
    function automatic logic [7:0] apply_case(input logic [7:0] ascii,
                                              input logic       shift);
        if (!shift && ascii >= ASCII_UC_FIRST && ascii <= ASCII_UC_LAST)
            return ascii + ASCII_CASE_OFS;
        return ascii;
    endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Show-ahead synchronous character FIFO with wrap-bit pointers.
// A pop on an empty queue is ignored; a push while full needs a same-cycle pop.
module kbd_char_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Scancode sequencer: prefix tracking, shift state, prefix timeout,
// and queueing of mapped characters for the CPU keyboard register.
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [7:0] map_scan,
    input  logic [7:0] map_ascii,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ack,
    output logic       fifo_full,
    output logic       overflow,
    input  logic       ovf_clear
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    kbd_state_e    state;
    kbd_state_e    next_state;
    logic          shift;
    logic          shift_set;
    logic          shift_clr;
    logic          cand;
    logic          push;
    logic          drop;
    logic          timeout;
    logic          empty;
    logic [CW-1:0] cnt;

    assign map_scan = scan_code;

    always_comb begin
        next_state = state;
        shift_set  = 1'b0;
        shift_clr  = 1'b0;
        cand       = 1'b0;
        if (scan_valid) begin
            unique case (state)
                IDLE: begin
                    if (scan_code == SC_BREAK)     next_state = BREAK;
                    else if (scan_code == SC_EXT)  next_state = EXT;
                    else if (is_shift(scan_code))  shift_set  = 1'b1;
                    else if (!is_discard(scan_code)) cand     = 1'b1;
                end
                BREAK: begin
                    shift_clr  = is_shift(scan_code);
                    next_state = IDLE;
                end
                EXT: begin
                    next_state = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    assign timeout = (state != IDLE) && !scan_valid && (cnt == TO_LAST);
    assign push    = cand && (map_ascii != 8'h00);
    // A pop in the same cycle frees the slot, so only an un-popped full push drops.
    assign drop    = push && fifo_full && !rd_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= timeout ? IDLE : next_state;
            if (shift_set)      shift <= 1'b1;
            else if (shift_clr) shift <= 1'b0;
            if (scan_valid || state == IDLE || timeout) cnt <= '0;
            else                                        cnt <= cnt + 1'b1;
            if (drop)           overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
        end
    end

    kbd_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (apply_case(map_ascii, shift)),
        .pop       (rd_ack),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (empty)
    );

    assign rd_valid = !empty;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl with a small scancode mapper model.
module tb_kbd_scan_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [7:0] map_scan;
    logic [7:0] map_ascii;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ack = 1'b0;
    logic       fifo_full;
    logic       overflow;
    logic       ovf_clear = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kbd_scan_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .map_scan   (map_scan),
        .map_ascii  (map_ascii),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ack     (rd_ack),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always_comb begin
        map_ascii = 8'h00;
        case (map_scan)
            8'h1C: map_ascii = 8'h41;
            8'h32: map_ascii = 8'h42;
            8'h69: map_ascii = 8'h31;
            8'h70: map_ascii = 8'h30;
            8'h75: map_ascii = 8'h38;
            default: map_ascii = 8'h00;
        endcase
    end

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic       ack;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       ef;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [7:0] code,
                                input logic ack, input logic clr,
                                input logic ev, input logic [7:0] ed,
                                input logic ef, input logic eo);
        vec_t r;
        r.v = v; r.code = code; r.ack = ack; r.clr = clr;
        r.ev = ev; r.ed = ed; r.ef = ef; r.eo = eo;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev,
                           input logic [7:0] ed, input logic ef,
                           input logic eo);
        chk({tag, " rd_valid"}, {7'd0, rd_valid}, {7'd0, ev});
        chk({tag, " rd_data"}, rd_data, ed);
        chk({tag, " fifo_full"}, {7'd0, fifo_full}, {7'd0, ef});
        chk({tag, " overflow"}, {7'd0, overflow}, {7'd0, eo});
    endtask

    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic ack1();
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
    endtask

    initial begin
        // test 1: 'a' with its break
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h61, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 1, 8'h61, 0, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h61, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        // test 2: shifted then unshifted
        vecs.push_back(mk(1, 8'h12, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h41, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 1, 8'h41, 0, 0));
        vecs.push_back(mk(1, 8'h12, 0, 0, 1, 8'h41, 0, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 0, 1, 8'h41, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h61, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        // test 3: extended keys, discards, unmapped
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h75, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h75, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h16, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'hFA, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        // push plus ack on an empty queue: push only
        vecs.push_back(mk(1, 8'h1C, 1, 0, 1, 8'h61, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        // test 4: fill, overflow, clear
        for (int i = 1; i <= DEPTH; i++)
            vecs.push_back(mk(1, 8'h69, 0, 0, 1, 8'h31, i == DEPTH, 0));
        vecs.push_back(mk(1, 8'h69, 0, 0, 1, 8'h31, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 8'h31, 1, 0));
        vecs.push_back(mk(1, 8'h69, 1, 0, 1, 8'h31, 1, 0));
        vecs.push_back(mk(1, 8'h69, 0, 1, 1, 8'h31, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 8'h31, 1, 0));
        for (int i = 1; i <= DEPTH; i++)
            vecs.push_back(mk(0, 8'h00, 1, 0, i != DEPTH,
                              (i != DEPTH) ? 8'h31 : 8'h00, 0, 0));

        #12;
        chk_all("reset", 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            scan_valid = vecs[i].v;
            scan_code  = vecs[i].code;
            rd_ack     = vecs[i].ack;
            ovf_clear  = vecs[i].clr;
            @(posedge clk); #1;
            scan_valid = 1'b0;
            rd_ack     = 1'b0;
            ovf_clear  = 1'b0;
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed,
                    vecs[i].ef, vecs[i].eo);
        end

        // test 5a: break survives TO-1 idle cycles, releases shift
        send(8'h12);
        send(8'hF0);
        repeat (TO - 1) @(posedge clk);
        #1;
        send(8'h12);
        send(8'h1C);
        chk("to_short data", rd_data, 8'h61);
        ack1();
        // test 5b: TO idle cycles return to IDLE, 12 becomes a make
        send(8'h12);
        send(8'hF0);
        repeat (TO) @(posedge clk);
        #1;
        send(8'h12);
        send(8'h1C);
        chk("to_long data", rd_data, 8'h41);
        ack1();
        chk("to_long drained", {7'd0, rd_valid}, 8'h00);
        send(8'hF0);
        send(8'h12);

        // test 6: async reset mid-prefix with entries queued
        send(8'h1C);
        send(8'h32);
        send(8'h69);
        chk("pre_rst data", rd_data, 8'h61);
        send(8'hE0);
        #2 reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst empty", {7'd0, rd_valid}, 8'h00);
        send(8'h70);
        chk_all("post_rst 70", 1, 8'h30, 0, 0);
        ack1();
        chk_all("post_rst drain", 0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
